// File: rtl/fp_mul_pipelined_pkg.sv
// Shared definitions for the pipelined floating-point multiplier:
// flag bit positions, operand classes and exponent bias helper.
package fp_mul_pipelined_pkg;

   localparam int FLAG_W         = 4;
   localparam int FLAG_INEXACT   = 0;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_INVALID   = 3;

   typedef enum logic [1:0] {
      CLS_ZERO   = 2'd0,
      CLS_NORMAL = 2'd1,
      CLS_INF    = 2'd2,
      CLS_NAN    = 2'd3
   } fp_class_e;

   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   // A zero exponent field means zero or subnormal; both are treated as zero.
   function automatic fp_class_e fp_classify(input logic exp_zero,
                                             input logic exp_ones,
                                             input logic man_nz);
      fp_class_e cls;
      if (exp_zero)
         cls = CLS_ZERO;
      else if (exp_ones)
         cls = man_nz ? CLS_NAN : CLS_INF;
      else
         cls = CLS_NORMAL;
      return cls;
   endfunction

endpackage

// File: rtl/fp_mul_pipelined_round.sv
// Combinational normalise, round-to-nearest-even and pack for a finite
// nonzero significand product; saturates to infinity or flushes to zero.
module fp_round_rne
   import fp_mul_pipelined_pkg::*;
#(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic                    i_sign,
   input  logic [2*MAN_W+1:0]      i_prod,
   input  logic signed [EXP_W+1:0] i_exp,
   output logic [EXP_W+MAN_W:0]    o_result,
   output logic [FLAG_W-1:0]       o_flags
);

   localparam int PROD_W = 2*MAN_W + 2;
   localparam int SEXP_W = EXP_W + 2;
   localparam logic signed [SEXP_W-1:0] EXP_ONE  = SEXP_W'(1);
   localparam logic signed [SEXP_W-1:0] EXP_ZERO = SEXP_W'(0);
   localparam logic signed [SEXP_W-1:0] EXP_MAX  = SEXP_W'((1 << EXP_W) - 1);

   logic                     w_shift;
   logic [PROD_W-1:0]        w_norm;
   logic signed [SEXP_W-1:0] w_exp_norm;
   logic signed [SEXP_W-1:0] w_exp_fin;
   logic [MAN_W-1:0]         w_man;
   logic                     w_guard;
   logic                     w_sticky;
   logic                     w_round_up;
   logic                     w_inexact;
   logic [MAN_W:0]           w_man_rnd;

   // Align so the hidden one always sits in the product MSB.
   assign w_shift    = i_prod[PROD_W-1];
   assign w_norm     = w_shift ? i_prod : {i_prod[PROD_W-2:0], 1'b0};
   assign w_exp_norm = w_shift ? (i_exp + EXP_ONE) : i_exp;

   assign w_man      = w_norm[PROD_W-2 -: MAN_W];
   assign w_guard    = w_norm[MAN_W];
   assign w_sticky   = |w_norm[MAN_W-1:0];
   assign w_round_up = w_guard & (w_sticky | w_man[0]);
   assign w_inexact  = w_guard | w_sticky;

   // A carry out of the rounded mantissa leaves zeros below it: bump exponent only.
   assign w_man_rnd  = {1'b0, w_man} + {{MAN_W{1'b0}}, w_round_up};
   assign w_exp_fin  = w_man_rnd[MAN_W] ? (w_exp_norm + EXP_ONE) : w_exp_norm;

   always_comb begin
      o_result               = {i_sign, w_exp_fin[EXP_W-1:0], w_man_rnd[MAN_W-1:0]};
      o_flags                = '0;
      o_flags[FLAG_INEXACT]  = w_inexact;
      if (w_exp_fin >= EXP_MAX) begin
         o_result               = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         o_flags[FLAG_OVERFLOW] = 1'b1;
         o_flags[FLAG_INEXACT]  = 1'b1;
      end else if (w_exp_fin <= EXP_ZERO) begin
         o_result                = {i_sign, {(EXP_W+MAN_W){1'b0}}};
         o_flags[FLAG_UNDERFLOW] = 1'b1;
         o_flags[FLAG_INEXACT]   = 1'b1;
      end
   end

endmodule

// File: rtl/fp_mul_pipelined.sv
// Three-stage floating-point multiplier with valid/ready flow control:
// unpack/classify, significand multiply + exponent add, round/pack.
module fp_mul_pipelined
   import fp_mul_pipelined_pkg::*;
#(
   parameter  int EXP_W  = 5,
   parameter  int MAN_W  = 10,
   parameter  int TAG_W  = 4,
   localparam int DATA_W = 1 + EXP_W + MAN_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic [TAG_W-1:0]  out_tag,
   output logic [FLAG_W-1:0] out_flags
);

   localparam int SIG_W  = MAN_W + 1;
   localparam int PROD_W = 2 * SIG_W;
   localparam int SEXP_W = EXP_W + 2;
   localparam int BIAS   = fp_bias(EXP_W);
   localparam logic [DATA_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   logic w_advance;

   // Every stage moves together; a stalled output freezes the whole pipe.
   assign w_advance = !out_valid || out_ready;
   assign in_ready  = w_advance;

   // ---------------- S1: unpack / classify ----------------
   logic [DATA_W-1:0] w_op  [2];
   logic [EXP_W-1:0]  w_exp [2];
   logic [SIG_W-1:0]  w_sig [2];
   fp_class_e         w_cls [2];

   assign w_op[0] = a;
   assign w_op[1] = b;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_unpack
         assign w_exp[gi] = w_op[gi][DATA_W-2 -: EXP_W];
         assign w_sig[gi] = {1'b1, w_op[gi][MAN_W-1:0]};
         assign w_cls[gi] = fp_classify(w_exp[gi] == '0, &w_exp[gi], |w_op[gi][MAN_W-1:0]);
      end
   endgenerate

   logic             r_s1_valid;
   logic [TAG_W-1:0] r_s1_tag;
   logic             r_s1_sign;
   fp_class_e        r_s1_cls [2];
   logic [EXP_W-1:0] r_s1_exp [2];
   logic [SIG_W-1:0] r_s1_sig [2];

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_s1_valid <= 1'b0;
      else if (w_advance)
         r_s1_valid <= in_valid;
   end

   always_ff @(posedge clk) begin
      if (w_advance) begin
         r_s1_tag  <= in_tag;
         r_s1_sign <= a[DATA_W-1] ^ b[DATA_W-1];
         r_s1_cls  <= w_cls;
         r_s1_exp  <= w_exp;
         r_s1_sig  <= w_sig;
      end
   end

   // ---------------- S2: multiply / exponent add ----------------
   logic [PROD_W-1:0]        w_prod;
   logic signed [SEXP_W-1:0] w_exp_sum;
   fp_class_e                w_kind;
   logic                     w_any_inf;
   logic                     w_any_zero;

   assign w_prod     = {{SIG_W{1'b0}}, r_s1_sig[0]} * {{SIG_W{1'b0}}, r_s1_sig[1]};
   assign w_exp_sum  = $signed({2'b00, r_s1_exp[0]}) + $signed({2'b00, r_s1_exp[1]})
                       - SEXP_W'(BIAS);
   assign w_any_inf  = (r_s1_cls[0] == CLS_INF)  || (r_s1_cls[1] == CLS_INF);
   assign w_any_zero = (r_s1_cls[0] == CLS_ZERO) || (r_s1_cls[1] == CLS_ZERO);

   always_comb begin
      w_kind = CLS_NORMAL;
      if (r_s1_cls[0] == CLS_NAN || r_s1_cls[1] == CLS_NAN || (w_any_inf && w_any_zero))
         w_kind = CLS_NAN;
      else if (w_any_inf)
         w_kind = CLS_INF;
      else if (w_any_zero)
         w_kind = CLS_ZERO;
   end

   logic                     r_s2_valid;
   logic [TAG_W-1:0]         r_s2_tag;
   logic                     r_s2_sign;
   fp_class_e                r_s2_kind;
   logic [PROD_W-1:0]        r_s2_prod;
   logic signed [SEXP_W-1:0] r_s2_exp;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_s2_valid <= 1'b0;
      else if (w_advance)
         r_s2_valid <= r_s1_valid;
   end

   always_ff @(posedge clk) begin
      if (w_advance) begin
         r_s2_tag  <= r_s1_tag;
         r_s2_sign <= r_s1_sign;
         r_s2_kind <= w_kind;
         r_s2_prod <= w_prod;
         r_s2_exp  <= w_exp_sum;
      end
   end

   // ---------------- S3: normalise / round / pack ----------------
   logic [DATA_W-1:0] w_rnd_result;
   logic [FLAG_W-1:0] w_rnd_flags;
   logic [DATA_W-1:0] w_s3_result;
   logic [FLAG_W-1:0] w_s3_flags;

   fp_round_rne #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_round (
      .i_sign   (r_s2_sign),
      .i_prod   (r_s2_prod),
      .i_exp    (r_s2_exp),
      .o_result (w_rnd_result),
      .o_flags  (w_rnd_flags)
   );

   always_comb begin
      w_s3_result = w_rnd_result;
      w_s3_flags  = w_rnd_flags;
      case (r_s2_kind)
         CLS_NAN: begin
            w_s3_result               = QNAN;
            w_s3_flags                = '0;
            w_s3_flags[FLAG_INVALID]  = 1'b1;
         end
         CLS_INF: begin
            w_s3_result = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_s3_flags  = '0;
         end
         CLS_ZERO: begin
            w_s3_result = {r_s2_sign, {(EXP_W+MAN_W){1'b0}}};
            w_s3_flags  = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         result    <= '0;
         out_tag   <= '0;
         out_flags <= '0;
      end else if (w_advance) begin
         out_valid <= r_s2_valid;
         result    <= w_s3_result;
         out_tag   <= r_s2_tag;
         out_flags <= w_s3_flags;
      end
   end

endmodule

// File: tb/tb_fp_mul_pipelined.sv
// Self-checking bench: directed vector table, stall/reset sequences and
// random traffic scored against an arithmetic reference model.
module tb_fp_mul_pipelined;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic [3:0]  out_tag;
   logic [3:0]  out_flags;

   fp_mul_pipelined #(
      .EXP_W (5),
      .MAN_W (10),
      .TAG_W (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .out_tag   (out_tag),
      .out_flags (out_flags)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] r;
      logic [3:0]  tag;
      logic [3:0]  f;
   } exp_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] r;
      logic [3:0]  f;
   } vec_t;

   exp_t        sb_q[$];
   exp_t        cur_exp;
   exp_t        mon_e;
   int          n_cmp = 0;
   int          n_err = 0;
   int          n_out = 0;
   logic        held_v = 1'b0;
   logic [23:0] held_val;
   logic        rand_done;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Reference: exact integer product of the significands, rounded by remainder.
   function automatic void model(input logic [15:0] x, input logic [15:0] y,
                                 output logic [15:0] r, output logic [3:0] f);
      int ex, ey, mx, my, e, sh, p, q, rem, half;
      bit s, zx, zy, ix, iy, nx, ny;
      ex = int'(x[14:10]); ey = int'(y[14:10]);
      mx = int'(x[9:0]);   my = int'(y[9:0]);
      s  = x[15] ^ y[15];
      zx = (ex == 0); zy = (ey == 0);
      ix = (ex == 31) && (mx == 0); iy = (ey == 31) && (my == 0);
      nx = (ex == 31) && (mx != 0); ny = (ey == 31) && (my != 0);
      r = 16'h0000; f = 4'b0000;
      if (nx || ny || (ix && zy) || (zx && iy)) begin
         r = 16'h7E00; f = 4'b1000;
      end else if (ix || iy) begin
         r = {s, 5'h1F, 10'h000};
      end else if (zx || zy) begin
         r = {s, 15'h0000};
      end else begin
         p    = (1024 + mx) * (1024 + my);
         sh   = (p >= 32'h0020_0000) ? 11 : 10;
         e    = ex + ey - 15 + (sh - 10);
         q    = p >> sh;
         rem  = p - (q << sh);
         half = 1 << (sh - 1);
         if (rem > half || (rem == half && (q % 2) == 1)) q++;
         if (q == 2048) begin
            q = 1024;
            e++;
         end
         if (e >= 31) begin
            r = {s, 5'h1F, 10'h000}; f = 4'b0101;
         end else if (e <= 0) begin
            r = {s, 15'h0000}; f = 4'b0011;
         end else begin
            r = {s, 5'(e), 10'(q)}; f = {3'b000, rem != 0};
         end
      end
   endfunction

   // Scoreboard and hold-stability monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (reset) begin
         sb_q.delete();
         held_v = 1'b0;
      end else begin
         if (held_v && out_valid)
            chk("hold_stable", {8'h00, result, out_tag, out_flags}, {8'h00, held_val});
         held_v   = out_valid && !out_ready;
         held_val = {result, out_tag, out_flags};
         if (in_valid && in_ready)
            sb_q.push_back(cur_exp);
         if (out_valid && out_ready) begin
            n_out++;
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_output: got result %h tag %h, required no output", result, out_tag);
            end else begin
               mon_e = sb_q.pop_front();
               chk($sformatf("out%0d_res_tag_flags", n_out),
                   {8'h00, result, out_tag, out_flags}, {8'h00, mon_e.r, mon_e.tag, mon_e.f});
            end
         end
      end
   end

   task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic [3:0] tt,
                       input logic [15:0] er, input logic [3:0] ef);
      int waited = 0;
      a        = ta;
      b        = tb;
      in_tag   = tt;
      cur_exp  = '{er, tt, ef};
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int c = 0;
      in_valid = 1'b0;
      while ((sb_q.size() != 0 || out_valid) && c < 200) begin
         @(posedge clk);
         #1;
         c++;
      end
      chk(name, sb_q.size(), 0);
   endtask

   task automatic check_latency(input logic [15:0] ta, input logic [15:0] tb, input logic [3:0] tt,
                                input logic [15:0] er, input logic [3:0] ef, input string name);
      int lat;
      send(ta, tb, tt, er, ef);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk(name, lat, 3);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[11];
      logic [15:0] ra, rb, er;
      logic [3:0]  ef;
      int          out_before;

      vecs[0]  = '{16'h3E00, 16'h3E00, 16'h4080, 4'b0000};
      vecs[1]  = '{16'h3C01, 16'h3E00, 16'h3E02, 4'b0001};
      vecs[2]  = '{16'hC000, 16'h3C00, 16'hC000, 4'b0000};
      vecs[3]  = '{16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0101};
      vecs[4]  = '{16'h0400, 16'h3800, 16'h0000, 4'b0011};
      vecs[5]  = '{16'h7C00, 16'h0000, 16'h7E00, 4'b1000};
      vecs[6]  = '{16'h7E00, 16'h3C00, 16'h7E00, 4'b1000};
      vecs[7]  = '{16'h0001, 16'h3C00, 16'h0000, 4'b0000};
      vecs[8]  = '{16'hFC00, 16'h4000, 16'hFC00, 4'b0000};
      vecs[9]  = '{16'h8000, 16'h3C00, 16'h8000, 4'b0000};
      vecs[10] = '{16'h3C00, 16'h3C00, 16'h3C00, 4'b0000};

      reset     = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      in_tag    = '0;
      out_ready = 1'b1;
      rand_done = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
      chk("rst_outputs", {8'h00, result, out_tag, out_flags}, 32'h0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Directed table; first entry also measures accept-to-valid latency.
      check_latency(vecs[0].a, vecs[0].b, 4'd5, vecs[0].r, vecs[0].f, "latency_1p5sq");
      for (int i = 1; i < 11; i++)
         send(vecs[i].a, vecs[i].b, 4'(i), vecs[i].r, vecs[i].f);
      drain("table_drained");

      // Stream of 8 with a 5-cycle consumer stall in the middle.
      out_before = n_out;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               ra = 16'h3C00 + 16'(i * 37);
               rb = 16'h4100 - 16'(i * 53);
               model(ra, rb, er, ef);
               send(ra, rb, 4'(i), er, ef);
            end
            in_valid = 1'b0;
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            out_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               chk($sformatf("stall%0d_valid_ready", k), {30'h0, out_valid, in_ready}, 32'h2);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain("stall_drained");
      chk("stall_count", n_out - out_before, 8);

      // Reset with three operations in flight.
      for (int i = 0; i < 3; i++) begin
         ra = 16'h4200 + 16'(i);
         model(ra, 16'h4000, er, ef);
         send(ra, 16'h4000, 4'(12 + i), er, ef);
      end
      reset    = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("rst_async_out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_async_in_ready", {31'h0, in_ready}, 32'h1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("no_stale%0d", k), {31'h0, out_valid}, 32'h0);
      end
      check_latency(16'h4000, 16'h4200, 4'd9, 16'h4600, 4'b0000, "latency_after_reset");
      drain("reset_drained");

      // Random traffic with random gaps and random consumer back-pressure.
      fork
         begin
            for (int i = 0; i < 200; i++) begin
               repeat ($urandom_range(0, 2)) idle();
               ra = 16'($urandom);
               rb = 16'($urandom);
               if ($urandom_range(0, 1) == 1) ra[14:10] = 5'($urandom_range(10, 20));
               if ($urandom_range(0, 1) == 1) rb[14:10] = 5'($urandom_range(10, 20));
               model(ra, rb, er, ef);
               send(ra, rb, 4'(i), er, ef);
            end
            in_valid  = 1'b0;
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain("random_drained");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fp_mul_pipelined.md
FP_MUL_PIPELINED -- requirements
Module: fp_mul_pipelined

Interface
REQ-001 The block SHALL have parameter EXP_W, default 5, exponent field width.
REQ-002 The block SHALL have parameter MAN_W, default 10, stored mantissa width.
REQ-003 The block SHALL have parameter TAG_W, default 4, sideband tag width carried alongside each operation.
REQ-004 The block SHALL have derived constant DATA_W = 1+EXP_W+MAN_W and bias = 2^(EXP_W-1)-1.
REQ-005 The block SHALL have port: clk input 1 clock; reset, asynchronous, active-high; clock clk.
REQ-006 The block SHALL have port: reset input 1 asynchronous active-high reset.
REQ-007 The block SHALL have ports: in_valid input 1 operand pair valid; in_ready output 1 block accepts operands.
REQ-008 The block SHALL have ports: a input DATA_W operand A; b input DATA_W operand B; in_tag input TAG_W sideband.
REQ-009 The block SHALL have ports: out_valid output 1 result valid; out_ready input 1 consumer accepts result.
REQ-010 The block SHALL have ports: result output DATA_W product; out_tag output TAG_W tag of that result; out_flags output 4 {invalid, overflow, underflow, inexact}.

Function
REQ-011 The datapath SHALL be 3 stages: S1 unpack/classify, S2 significand multiply + exponent add, S3 normalise/round/pack; latency 3 cycles from accept to out_valid when unstalled.
REQ-012 Transfers SHALL occur on in_valid&&in_ready (input) and out_valid&&out_ready (output); throughput 1 op/cycle.
REQ-013 The pipeline SHALL advance only when advance = !out_valid || out_ready; in_ready SHALL equal advance (combinational); no stage may drop or duplicate an operation.
REQ-014 Each stage SHALL carry a valid bit; bubbles propagate; tag and flags travel with their operation.
REQ-015 Outputs result, out_tag, out_flags SHALL hold stable while out_valid && !out_ready.
REQ-016 Significand product SHALL be (MAN_W+1)x(MAN_W+1) -> 2*MAN_W+2 bits with hidden 1; exponent math SHALL use signed EXP_W+2 bits: ea+eb-bias.
REQ-017 Normalise: if product MSB set, shift right 1 and exponent +1; then round-to-nearest-even on guard/sticky; a rounding carry-out SHALL renormalise and increment exponent.
REQ-018 Subnormal inputs SHALL be flushed to signed zero before classification; subnormal results SHALL be flushed to signed zero with underflow=1, inexact=1.
REQ-019 Final biased exponent >= 2^EXP_W-1 SHALL yield signed infinity, overflow=1, inexact=1.
REQ-020 Any NaN input, or inf x zero, SHALL yield canonical qNaN {0, all-ones exp, 1 followed by zeros} with invalid=1.
REQ-021 inf x finite-nonzero SHALL yield signed inf, flags 0; zero x finite SHALL yield signed zero, flags 0; sign always a[MSB]^b[MSB] except NaN.
REQ-022 inexact SHALL be set whenever discarded guard/sticky bits are nonzero.

Reset
REQ-023 On reset all stage valid bits, out_valid, result, out_tag and out_flags SHALL clear to 0 immediately; in-flight ops are discarded.
REQ-024 in_ready SHALL read 1 during and after reset (since out_valid=0).
REQ-025 Datapath registers without valid qualification MAY be left unreset.

Structure
REQ-026 A shared package SHALL hold the flag-index constants, a classify enum {ZERO, NORMAL, INF, NAN}, and a function computing bias from EXP_W.
REQ-027 One sub-module fp_round_rne (normalise + RNE + pack, combinational) SHALL be instantiated in S3.

Verification
REQ-028 0x3E00 x 0x3E00 (1.5x1.5), tag 5 -> 0x4080, tag 5, flags 0, exactly 3 cycles later.
REQ-029 0x3C01 x 0x3E00 (tie) -> 0x3E02, inexact=1; 0xC000 x 0x3C00 -> 0xC000, flags 0.
REQ-030 0x7BFF x 0x7BFF -> 0x7C00 overflow+inexact; 0x0400 x 0x3800 -> 0x0000 underflow+inexact.
REQ-031 0x7C00 x 0x0000 -> 0x7E00 invalid; 0x7E00 x 0x3C00 -> 0x7E00 invalid; 0x0001 x 0x3C00 -> 0x0000, flags 0.
REQ-032 Stream 8 ops back-to-back, drop out_ready for 5 cycles mid-stream -> in_ready low while stalled, all 8 results in order with correct tags, none lost or repeated.
REQ-033 Assert reset with 3 ops in flight -> out_valid 0 next edge, no stale result after release, next op correct after 3 cycles.
